ssd_source_select: RTL and testbench
====================================

# ssd_source_select

Selects which architectural value of the RISC-V core is shown on the four-digit seven-segment display, and produces the registered 13-bit binary number consumed directly by the display driver. It sits between the core (PC, fetched instruction, register-file debug read port) and the seven-segment driver. Two push-buttons step through register indices and two slide switches choose the source. Values that do not fit the driver's 13-bit input saturate and raise an overflow flag.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive cycles a synchronized button must hold a new level before it is accepted (10 ms at 100 MHz).
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_next`  in  1  raw push-button, asynchronous to `clk`, active-high; increments the register index.
- `btn_prev`  in  1  raw push-button, asynchronous to `clk`, active-high; decrements the register index.
- `mode_sw`  in  2  raw slide switches, asynchronous to `clk`, selecting the source:
  - 0 = register `x[reg_idx]`
  - 1 = PC
  - 2 = instr[12:0]
  - 3 = reg_idx itself
- `pc`  in  32  current program counter, synchronous to `clk`.
- `instr`  in  32  current instruction word, synchronous to `clk`.
- `reg_rd_data`  in  32  combinational register-file read data for address `reg_rd_addr`.
- `reg_rd_addr`  out  5  register-file debug read address; always equals `reg_idx`.
- `reg_idx`  out  5  currently selected register index, for LEDs.
- `num`  out  13  value to display; feeds the driver's `num` input.
- `over`  out  1  high while the selected source exceeds 8191.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer:
  - A counter counts while the synchronized input differs from the accepted state, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the accepted state flips.
  - A flip of the accepted state from 0 to 1 emits a one-cycle `press` pulse.
  - Releases emit nothing.
- `mode_sw` passes through a 2-FF synchronizer only (no debounce).
- `reg_idx` is 5 bits and wraps in both directions:
  - next-press at 31 gives 0.
  - prev-press at 0 gives 31.
  - next and prev presses in the same cycle cancel; `reg_idx` is unchanged.
- Source value `src` (32-bit, unsigned) is taken per the synchronized mode:
  - mode 0: `reg_rd_data`. For index 0 this is whatever the register file returns; no special-casing here.
  - mode 1: `pc`.
  - mode 2: zero-extended `instr[12:0]`.
  - mode 3: zero-extended `reg_idx`.
- Saturation:
  - If `src` > 8191: `num` <= 8191, `over` <= 1.
  - Otherwise: `num` <= `src[12:0]`, `over` <= 0.
- `num` and `over` are updated every cycle; the block has no hold or enable.

## Timing
- Reset values:
  - `reg_idx` = 0, `reg_rd_addr` = 0, `num` = 0, `over` = 0.
  - Synchronizers, debounce counters and accepted button states = 0.
  - Synchronized mode = 0.
- Button latency: from a clean raw rising edge to `reg_idx` change is 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 (edge pulse register) + 1 (`reg_idx` register).
- Bounce handling: a level held for fewer than `DEBOUNCE_CYCLES` consecutive cycles is ignored, and any bounce restarts the count.
- A held button produces exactly one step; there is no auto-repeat.
- Source-to-output latency: one cycle from `pc`/`instr`/`reg_rd_data` to `num`/`over`.
- Mode change: 2 synchronizer cycles + 1 cycle to `num`.
- `reg_idx` change:
  - `reg_rd_addr` changes in the same cycle as `reg_idx`.
  - `num` reflects the new register one cycle later (register file read is combinational).
- Asserting `rst` mid-debounce or mid-press clears all state immediately.
- A button still held when `rst` deasserts is accepted after the debounce period and steps `reg_idx` once, to 1.

## Structure
- Shared display package:
  - mode encodings `SRC_REG`, `SRC_PC`, `SRC_INSTR`, `SRC_IDX`.
  - `DISP_MAX` = 8191.
  - `DISP_W` = 13.
- Sub-module `button_debouncer`:
  - parameter `DEBOUNCE_CYCLES`.
  - ports `clk`, `rst`, `btn_raw`, `btn_level`, `btn_press`.
  - contains the synchronizer, the counter and the rising-edge detector.
  - instantiated twice.
- Top level contains the mode synchronizer, the index counter, the source mux and the saturation register.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4.
- Reset, then mode 1 with `pc` = 1234 -> `num` = 1234 and `over` = 0 four cycles after the switch change; all outputs 0 during reset.
- Mode 1 with `pc` = 8191, then 8192, then 0xFFFF_FFFF -> `num` = 8191/`over` = 0, then 8191/1, then 8191/1.
- `btn_next` bouncing 1-0-1 every 2 cycles for 20 cycles, then held for 10 -> exactly one increment; `reg_idx` goes 0 to 1, and `reg_rd_addr` = 1 in the same cycle.
- `btn_prev` pressed at `reg_idx` = 0 -> 31; then 31 single `btn_next` presses -> `reg_idx` = 30; one more press -> 31, next press -> 0.
- Both buttons pressed with identical timing -> `reg_idx` unchanged.
- Mode 0 with `reg_idx` = 5 and register-file model `x5` = 0x10 -> `num` = 16.
- `rst` pulsed mid-debounce with `btn_next` held -> `reg_idx` = 0 during reset, then `reg_idx` = 1 four debounce cycles (plus pipeline) after release.

Source files
------------

// File: rtl/ssd_source_select_pkg.sv
// Shared definitions for the seven-segment source selector.
//   src_mode_e : encoding of the two mode slide switches
//   DISP_W     : width of the display driver's binary input
//   DISP_MAX   : largest value the driver can show
//   saturate() : clamps a 32-bit source to the display range and flags overflow
package ssd_source_select_pkg;

    localparam int unsigned DISP_W   = 13;
    localparam int unsigned DISP_MAX = 8191;

    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_PC    = 2'd1,
        SRC_INSTR = 2'd2,
        SRC_IDX   = 2'd3
    } src_mode_e;

    typedef struct packed {
        logic              over;
        logic [DISP_W-1:0] num;
    } disp_t;

    function automatic disp_t saturate(input logic [31:0] v);
        disp_t d;
        if (v > 32'(DISP_MAX)) begin
            d.over = 1'b1;
            d.num  = DISP_W'(DISP_MAX);
        end else begin
            d.over = 1'b0;
            d.num  = v[DISP_W-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/ssd_source_select_button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, level debouncer and press detector.
//   clk, rst   : system clock, asynchronous active-high reset
//   btn_raw    : raw button, asynchronous to clk
//   btn_level  : debounced (accepted) button level
//   btn_press  : one-cycle pulse, one cycle after the accepted level rises
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic            press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Any return to the accepted level clears the count, so bounces restart it.
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/ssd_source_select.sv
// Chooses which core value is shown on the seven-segment display.
//   btn_next/btn_prev : raw buttons stepping the register index up/down (wrapping)
//   mode_sw           : raw switches selecting register / PC / instr[12:0] / index
//   pc, instr         : core state, synchronous to clk
//   reg_rd_data       : combinational register-file read data for reg_rd_addr
//   reg_rd_addr       : register-file debug address (== reg_idx)
//   reg_idx           : selected register index
//   num, over         : registered, saturated 13-bit display value and overflow flag
module ssd_source_select
    import ssd_source_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic [1:0]        mode_sw,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic [31:0]       reg_rd_data,
    output logic [4:0]        reg_rd_addr,
    output logic [4:0]        reg_idx,
    output logic [DISP_W-1:0] num,
    output logic              over
);

    logic next_press, prev_press;
    logic next_level, prev_level;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_next),
        .btn_level(next_level),
        .btn_press(next_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_prev (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_prev),
        .btn_level(prev_level),
        .btn_press(prev_press)
    );

    logic [1:0]        mode_sync_q, mode_q;
    logic [4:0]        reg_idx_q, reg_idx_d;
    logic [31:0]       src;
    disp_t             disp_d;
    logic [DISP_W-1:0] num_q;
    logic              over_q;

    always_comb begin
        reg_idx_d = reg_idx_q;
        // Simultaneous presses cancel; 5-bit arithmetic gives the wrap-around.
        unique case ({next_press, prev_press})
            2'b10:   reg_idx_d = reg_idx_q + 5'd1;
            2'b01:   reg_idx_d = reg_idx_q - 5'd1;
            default: reg_idx_d = reg_idx_q;
        endcase
    end

    always_comb begin
        src = '0;
        case (mode_q)
            SRC_REG:   src = reg_rd_data;
            SRC_PC:    src = pc;
            SRC_INSTR: src = {{(32 - DISP_W){1'b0}}, instr[DISP_W-1:0]};
            SRC_IDX:   src = {27'd0, reg_idx_q};
            default:   src = '0;
        endcase
        disp_d = saturate(src);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_sync_q <= 2'd0;
            mode_q      <= 2'd0;
            reg_idx_q   <= 5'd0;
            num_q       <= '0;
            over_q      <= 1'b0;
        end else begin
            mode_sync_q <= mode_sw;
            mode_q      <= mode_sync_q;
            reg_idx_q   <= reg_idx_d;
            num_q       <= disp_d.num;
            over_q      <= disp_d.over;
        end
    end

    assign reg_idx     = reg_idx_q;
    assign reg_rd_addr = reg_idx_q;
    assign num         = num_q;
    assign over        = over_q;

    // Upper instruction bits and the debounced levels are intentionally not used here.
    logic unused_bits;
    assign unused_bits = ^{instr[31:DISP_W], next_level, prev_level};

endmodule

// File: tb/tb_ssd_source_select.sv
module tb_ssd_source_select;

    logic        clk;
    logic        rst;
    logic        btn_next, btn_prev;
    logic [1:0]  mode_sw;
    logic [31:0] pc, instr, reg_rd_data;
    logic [4:0]  reg_rd_addr, reg_idx;
    logic [12:0] num;
    logic        over;

    int n_checks = 0;
    int n_pass   = 0;

    ssd_source_select #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .mode_sw    (mode_sw),
        .pc         (pc),
        .instr      (instr),
        .reg_rd_data(reg_rd_data),
        .reg_rd_addr(reg_rd_addr),
        .reg_idx    (reg_idx),
        .num        (num),
        .over       (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x0 = 0, x5 = 0x10, others 0x1000 + index.
    function automatic logic [31:0] rf_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == 5'd5) return 32'h10;
        return 32'h1000 + {27'd0, a};
    endfunction

    assign reg_rd_data = rf_model(reg_rd_addr);

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [12:0] exp_num;
        logic        exp_over;
    } vec_t;

    vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic press(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    initial begin
        vecs[0] = '{2'd1, 32'd1234,       32'd0,          13'd1234, 1'b0};
        vecs[1] = '{2'd1, 32'd8191,       32'd0,          13'd8191, 1'b0};
        vecs[2] = '{2'd1, 32'd8192,       32'd0,          13'd8191, 1'b1};
        vecs[3] = '{2'd1, 32'hFFFF_FFFF,  32'd0,          13'd8191, 1'b1};
        vecs[4] = '{2'd2, 32'hFFFF_FFFF,  32'hFFFF_E123,  13'd291,  1'b0};
        vecs[5] = '{2'd2, 32'd0,          32'h0000_1FFF,  13'd8191, 1'b0};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  13'd0,    1'b0};
        vecs[7] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  13'd0,    1'b0};

        rst = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        mode_sw = 2'd1;
        pc = 32'd1234;
        instr = 32'd0;
        tick(3);
        check("rst_num", {19'd0, num}, 32'd0);
        check("rst_over", {31'd0, over}, 32'd0);
        check("rst_reg_idx", {27'd0, reg_idx}, 32'd0);
        check("rst_reg_rd_addr", {27'd0, reg_rd_addr}, 32'd0);

        mode_sw = 2'd0;
        tick(3);
        rst = 1'b0;
        tick(3);
        check("mode0_idx0", {19'd0, num}, 32'd0);

        // Mode change: two synchronizer cycles plus one output cycle.
        mode_sw = 2'd1;
        tick(2);
        check("mode_lat_2", {19'd0, num}, 32'd0);
        tick(1);
        check("mode_lat_3", {19'd0, num}, 32'd1234);
        tick(1);
        check("mode_lat_4_over", {31'd0, over}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            mode_sw = vecs[i].mode;
            pc      = vecs[i].pc;
            instr   = vecs[i].instr;
            tick(4);
            check($sformatf("vec%0d_num", i), {19'd0, num}, {19'd0, vecs[i].exp_num});
            check($sformatf("vec%0d_over", i), {31'd0, over}, {31'd0, vecs[i].exp_over});
        end

        // Source-to-output latency is one cycle.
        mode_sw = 2'd1;
        pc = 32'd100;
        tick(4);
        pc = 32'd200;
        #1;
        check("src_lat_0", {19'd0, num}, 32'd100);
        tick(1);
        check("src_lat_1", {19'd0, num}, 32'd200);

        // Bouncing next button: 2-cycle pulses never reach the debounce count.
        mode_sw = 2'd0;
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            tick(2);
            btn_next = 1'b0;
            tick(2);
        end
        check("bounce_ignored", {27'd0, reg_idx}, 32'd0);
        btn_next = 1'b1;
        tick(7);
        check("press_lat_7", {27'd0, reg_idx}, 32'd0);
        tick(1);
        check("press_lat_8", {27'd0, reg_idx}, 32'd1);
        check("press_rd_addr", {27'd0, reg_rd_addr}, 32'd1);
        tick(2);
        btn_next = 1'b0;
        tick(12);
        check("bounce_one_step", {27'd0, reg_idx}, 32'd1);

        press(1'b0, 1'b1);
        check("prev_to_0", {27'd0, reg_idx}, 32'd0);
        press(1'b0, 1'b1);
        check("prev_wrap_31", {27'd0, reg_idx}, 32'd31);
        for (int i = 0; i < 31; i++) press(1'b1, 1'b0);
        check("next_x31_30", {27'd0, reg_idx}, 32'd30);
        press(1'b1, 1'b0);
        check("next_31", {27'd0, reg_idx}, 32'd31);
        press(1'b1, 1'b0);
        check("next_wrap_0", {27'd0, reg_idx}, 32'd0);
        press(1'b1, 1'b1);
        check("both_cancel", {27'd0, reg_idx}, 32'd0);

        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        check("idx_5", {27'd0, reg_idx}, 32'd5);
        mode_sw = 2'd0;
        tick(4);
        check("x5_num", {19'd0, num}, 32'd16);
        mode_sw = 2'd3;
        tick(4);
        check("idx_mode_num", {19'd0, num}, 32'd5);
        mode_sw = 2'd0;
        tick(4);

        // Register read follows reg_idx with one cycle of output latency.
        btn_next = 1'b1;
        tick(8);
        check("step6_idx", {27'd0, reg_idx}, 32'd6);
        check("step6_num_old", {19'd0, num}, 32'd16);
        tick(1);
        check("step6_num_new", {19'd0, num}, 32'h1006);
        btn_next = 1'b0;
        tick(10);

        // Reset in the middle of a debounce with the button still held.
        btn_next = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check("async_rst_idx", {27'd0, reg_idx}, 32'd0);
        check("async_rst_num", {19'd0, num}, 32'd0);
        tick(2);
        check("rst_held_idx", {27'd0, reg_idx}, 32'd0);
        rst = 1'b0;
        tick(7);
        check("post_rst_lat_7", {27'd0, reg_idx}, 32'd0);
        tick(1);
        check("post_rst_lat_8", {27'd0, reg_idx}, 32'd1);
        check("post_rst_rd_addr", {27'd0, reg_rd_addr}, 32'd1);
        tick(1);
        check("post_rst_num", {19'd0, num}, 32'h1001);

        // A long hold still gives exactly one step.
        tick(30);
        check("no_autorepeat", {27'd0, reg_idx}, 32'd1);
        btn_next = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
